// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
// State encoding, instruction patterns and error codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
  localparam logic [63:0] CPU_RESET_PC = 64'h8000_0000;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic is_op_imm(
    input logic [31:0] w
  );
    return w[6:0] == OPC_OP_IMM;
  endfunction

  function automatic logic [4:0] rd_of(
    input logic [31:0] w
  );
    return w[11:7];
  endfunction

endpackage

// File: rtl/seq_fetch_timer.sv
// Counts FETCH cycles spent waiting for an ack.
// expire_o flags the last allowed wait cycle.
module seq_fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [7:0] LAST =
    8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Clear dominates; saturate so a stuck
  // enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer.
// Owns PC, instruction register and instret.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = CPU_RESET_PC,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic [63:0] exu_result,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [63:0] rd_wdata,
  output logic [63:0] pc,
  output logic [63:0] instret,
  output logic        halt,
  output logic        err,
  output logic [1:0]  err_code
);

  state_e      state_q;
  logic [63:0] pc_q;
  logic [31:0] inst_q;
  logic [63:0] instret_q;
  logic [63:0] result_q;
  logic        req_q;
  logic        wen_q;
  logic        halt_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic in_fetch;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expire;

  assign in_fetch = (state_q == ST_FETCH);
  assign tmr_clr  = !in_fetch || imem_ack;
  assign tmr_en   = in_fetch && !imem_ack;

  seq_fetch_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  // Sequencer FSM; outputs are registered so
  // imem_ack never reaches imem_req directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      instret_q  <= '0;
      result_q   <= '0;
      req_q      <= 1'b0;
      wen_q      <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      wen_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            state_q <= ST_DECODE;
            req_q   <= 1'b0;
          end else if (tmr_expire) begin
            state_q    <= ST_ERR;
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end
        end
        ST_DECODE: begin
          if (inst_q == INST_EBREAK) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
          end else if (is_op_imm(inst_q)) begin
            state_q <= ST_EXEC;
          end else begin
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            err_code_q <= ERR_ILLEGAL;
          end
        end
        ST_EXEC: begin
          result_q <= exu_result;
          state_q  <= ST_WB;
          wen_q    <= (rd_of(inst_q) != 5'd0);
        end
        ST_WB: begin
          pc_q      <= pc_q + 64'd4;
          instret_q <= instret_q + 64'd1;
          state_q   <= ST_FETCH;
          req_q     <= 1'b1;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign rd_wen    = wen_q;
  assign rd_addr   = rd_of(inst_q);
  assign rd_wdata  = result_q;
  assign pc        = pc_q;
  assign instret   = instret_q;
  assign halt      = halt_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed plus random
// instruction streams against a retire-count model.
module tb_cpu_seq_ctrl;

  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam int TMO = 16;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [63:0] exu_result = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] inst;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [63:0] rd_wdata;
  logic [63:0] pc;
  logic [63:0] instret;
  logic        halt;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int n_ret  = 0;

  always #5 clock = ~clock;

  cpu_seq_ctrl #(
    .RESET_PC       (RPC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .exu_result (exu_result),
    .rd_wen     (rd_wen),
    .rd_addr    (rd_addr),
    .rd_wdata   (rd_wdata),
    .pc         (pc),
    .instret    (instret),
    .halt       (halt),
    .err        (err),
    .err_code   (err_code)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_pc(
    input int n
  );
    return RPC + 64'(n) * 64'd4;
  endfunction

  task automatic reset_and_start;
    reset = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    tick;
    tick;
    chk("rst_pc", pc, RPC);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_flags", 64'({rd_wen, halt, err}), 64'd0);
    chk("rst_errcode", 64'(err_code), 64'd0);
    chk("rst_wdata", rd_wdata, 64'd0);
    n_ret = 0;
    reset = 1'b1;
    chk("idle_req", 64'(imem_req), 64'd0);
    tick;
    chk("start_req", 64'(imem_req), 64'd1);
  endtask

  // Caller is in a FETCH cycle on entry.
  task automatic run_inst(
    input logic [31:0] w,
    input int dly,
    input logic [63:0] ev
  );
    int cyc;
    logic [4:0] rd;
    cyc = 0;
    rd = w[11:7];
    exu_result = ev;
    for (int i = 0; i <= dly; i++) begin
      chk("fetch_req", 64'(imem_req), 64'd1);
      chk("fetch_addr", imem_addr, exp_pc(n_ret));
      chk("fetch_noerr", 64'(err), 64'd0);
      if (i == dly) begin
        imem_ack = 1'b1;
        imem_rdata = w;
      end
      tick;
      cyc++;
      imem_ack = 1'b0;
      imem_rdata = $urandom;
    end
    chk("dec_req", 64'(imem_req), 64'd0);
    chk("dec_inst", 64'(inst), 64'(w));
    chk("dec_wen", 64'(rd_wen), 64'd0);
    chk("dec_halt", 64'(halt), 64'd0);
    if (w == EBRK) begin
      tick;
      chk("halt_set", 64'(halt), 64'd1);
      chk("halt_err", 64'(err), 64'd0);
      for (int k = 0; k < 20; k++) begin
        imem_ack = k[0];
        tick;
        chk("halt_req", 64'(imem_req), 64'd0);
        chk("halt_pc", pc, exp_pc(n_ret));
        chk("halt_ret", instret, 64'(n_ret));
        chk("halt_sticky", 64'(halt), 64'd1);
        chk("halt_wen", 64'(rd_wen), 64'd0);
      end
      imem_ack = 1'b0;
    end else if (w[6:0] == 7'b0010011) begin
      tick;
      cyc++;
      chk("exec_wen", 64'(rd_wen), 64'd0);
      tick;
      cyc++;
      exu_result = ~ev;
      #1;
      chk("wb_wen", 64'(rd_wen), 64'(rd != 5'd0));
      chk("wb_rd", 64'(rd_addr), 64'(rd));
      chk("wb_data", rd_wdata, ev);
      chk("wb_pc", pc, exp_pc(n_ret));
      chk("wb_req", 64'(imem_req), 64'd0);
      tick;
      cyc++;
      n_ret++;
      chk("nxt_pc", pc, exp_pc(n_ret));
      chk("nxt_ret", instret, 64'(n_ret));
      chk("nxt_wen", 64'(rd_wen), 64'd0);
      chk("nxt_req", 64'(imem_req), 64'd1);
      chk("cycles", 64'(cyc), 64'(dly + 4));
    end else begin
      tick;
      chk("ill_err", 64'(err), 64'd1);
      chk("ill_code", 64'(err_code), 64'd1);
      chk("ill_pc", pc, exp_pc(n_ret));
      for (int k = 0; k < 8; k++) begin
        chk("ill_req", 64'(imem_req), 64'd0);
        chk("ill_wen", 64'(rd_wen), 64'd0);
        chk("ill_hold", 64'(err_code), 64'd1);
        tick;
      end
    end
  endtask

  function automatic logic [31:0] rand_opimm();
    logic [31:0] r;
    r = $urandom;
    r[6:0] = 7'b0010011;
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  initial begin
    logic [63:0] ev;
    logic [31:0] w;

    reset_and_start();

    // addi x1,x0,-1 with zero-wait ack
    run_inst(32'hFFF0_0093, 0, 64'h1);

    // addi x0,x0,5 with 3-cycle ack delay
    ev = {$urandom, $urandom};
    run_inst(32'h0050_0013, 3, ev);

    // random OP-IMM stream
    for (int n = 0; n < 24; n++) begin
      ev = {$urandom, $urandom};
      w = rand_opimm();
      run_inst(w, $urandom_range(0, TMO - 1), ev);
    end

    // ack on the last allowed fetch cycle
    run_inst(rand_opimm(), TMO - 1, 64'hDEAD_BEEF);
    chk("late_ack_ok", 64'(err), 64'd0);

    // reset mid-fetch, ack pulsed during reset
    tick;
    chk("mid_req_pre", 64'(imem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_req_drop", 64'(imem_req), 64'd0);
    chk("mid_pc", pc, RPC);
    chk("mid_inst", 64'(inst), 64'd0);
    chk("mid_ret", instret, 64'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hFFF0_0093;
    tick;
    imem_ack = 1'b0;
    tick;
    chk("mid_inst_hold", 64'(inst), 64'd0);
    n_ret = 0;
    reset = 1'b1;
    imem_ack = 1'b1;
    chk("mid_idle_req", 64'(imem_req), 64'd0);
    tick;
    imem_ack = 1'b0;
    chk("mid_restart", 64'(imem_req), 64'd1);
    chk("mid_addr", imem_addr, RPC);
    chk("mid_ign_ack", 64'(inst), 64'd0);

    run_inst(rand_opimm(), 0, 64'h5);
    run_inst(rand_opimm(), 2, 64'h6);

    // fetch timeout
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_req", 64'(imem_req), 64'd1);
      chk("tmo_wait", 64'(err), 64'd0);
      tick;
    end
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_code", 64'(err_code), 64'd2);
    chk("tmo_req_off", 64'(imem_req), 64'd0);
    chk("tmo_pc", pc, exp_pc(n_ret));
    for (int k = 0; k < 5; k++) begin
      imem_ack = 1'b1;
      tick;
      chk("tmo_sticky", 64'(err_code), 64'd2);
    end
    imem_ack = 1'b0;

    // illegal R-type opcode
    reset_and_start();
    run_inst(rand_opimm(), 1, 64'h77);
    run_inst(32'h0000_0033, 0, 64'h0);

    // ebreak after a few instructions
    reset_and_start();
    for (int n = 0; n < 3; n++) begin
      run_inst(rand_opimm(), $urandom_range(0, 4),
               {$urandom, $urandom});
    end
    run_inst(EBRK, 1, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
